// File: rtl/rtype_sequencer.sv
// ============================================================================
// Module   : rtype_sequencer
// Purpose  : Multi-cycle FETCH/DECODE/EXEC/WB sequencer for the R-type
//            integer datapath. It fetches over a req/ack port, decodes into
//            the 4-bit ALU control, stretches EXEC for MUL and pulses rf_we.
// Options  : RTYPE_SEQ_PERF_EN adds the cycle_count/retire_count outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rtype_sequencer #(
  parameter int                  PC_WIDTH   = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
  parameter int                  MUL_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [31:0]         imem_rdata,
  output logic [31:0]         instr,
  output logic [3:0]          alu_op,
  output logic                rf_we,
  output logic [PC_WIDTH-1:0] pc,
  output logic                busy,
  output logic                illegal
`ifdef RTYPE_SEQ_PERF_EN
  ,
  output logic [31:0]         cycle_count,
  output logic [31:0]         retire_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [6:0] C_OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] C_F7_ZERO   = 7'h00;
  localparam logic [6:0] C_F7_ALT    = 7'h20;

  localparam logic [3:0] C_OP_AND = 4'b0000;
  localparam logic [3:0] C_OP_OR  = 4'b0001;
  localparam logic [3:0] C_OP_ADD = 4'b0010;
  localparam logic [3:0] C_OP_SLL = 4'b0011;
  localparam logic [3:0] C_OP_SUB = 4'b0100;
  localparam logic [3:0] C_OP_SRL = 4'b0101;
  localparam logic [3:0] C_OP_MUL = 4'b0110;
  localparam logic [3:0] C_OP_XOR = 4'b0111;

  // Counter holds remaining extra EXEC cycles, so MUL loads MUL_CYCLES-1.
  localparam logic [3:0]          C_MUL_LOAD = 4'(MUL_CYCLES - 1);
  localparam logic [PC_WIDTH-1:0] C_PC_STEP  = PC_WIDTH'(4);

  state_t              state_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic [31:0]         instr_q;
  logic [3:0]          alu_op_q;
  logic [3:0]          mul_cnt_q;
  logic                imem_req_q;
  logic                rf_we_q;
  logic                busy_q;
  logic                illegal_q;

  logic [3:0]          dec_op_d;
  logic                dec_legal_d;
  logic                dec_mul_d;

  logic [6:0]          funct7_w;
  logic [2:0]          funct3_w;
  logic                f7_zero_w;

  assign funct7_w  = instr_q[31:25];
  assign funct3_w  = instr_q[14:12];
  assign f7_zero_w = (funct7_w == C_F7_ZERO);

  // Decode the latched instruction into ALU control and a legality flag.
  always_comb begin
    dec_op_d    = C_OP_AND;
    dec_legal_d = 1'b0;
    dec_mul_d   = 1'b0;
    if (instr_q[6:0] == C_OPC_RTYPE) begin
      case (funct3_w)
        3'd0: begin
          if (f7_zero_w) begin
            dec_op_d    = C_OP_ADD;
            dec_legal_d = 1'b1;
          end else if (funct7_w == C_F7_ALT) begin
            dec_op_d    = C_OP_SUB;
            dec_legal_d = 1'b1;
          end
        end
        3'd7: begin dec_op_d = C_OP_AND; dec_legal_d = f7_zero_w; end
        3'd6: begin dec_op_d = C_OP_OR;  dec_legal_d = f7_zero_w; end
        3'd1: begin dec_op_d = C_OP_SLL; dec_legal_d = f7_zero_w; end
        3'd5: begin dec_op_d = C_OP_SRL; dec_legal_d = f7_zero_w; end
        3'd2: begin
          dec_op_d    = C_OP_MUL;
          dec_legal_d = f7_zero_w;
          dec_mul_d   = 1'b1;
        end
        3'd4: begin dec_op_d = C_OP_XOR; dec_legal_d = f7_zero_w; end
        default: dec_legal_d = 1'b0;
      endcase
    end
  end

  // Sequencer FSM; every strobe is registered alongside the state transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      alu_op_q   <= C_OP_AND;
      mul_cnt_q  <= '0;
      imem_req_q <= 1'b0;
      rf_we_q    <= 1'b0;
      busy_q     <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      rf_we_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (run) begin
            state_q    <= S_FETCH;
            imem_req_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        S_FETCH: begin
          if (imem_ack) begin
            instr_q    <= imem_rdata;
            imem_req_q <= 1'b0;
            state_q    <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (dec_legal_d) begin
            alu_op_q  <= dec_op_d;
            mul_cnt_q <= dec_mul_d ? C_MUL_LOAD : 4'd0;
            state_q   <= S_EXEC;
          end else begin
            illegal_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= S_HALT;
          end
        end
        S_EXEC: begin
          if (mul_cnt_q == 4'd0) begin
            rf_we_q <= 1'b1;
            state_q <= S_WB;
          end else begin
            mul_cnt_q <= mul_cnt_q - 4'd1;
          end
        end
        S_WB: begin
          pc_q <= pc_q + C_PC_STEP;
          if (run) begin
            imem_req_q <= 1'b1;
            state_q    <= S_FETCH;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q    <= S_IDLE;
          imem_req_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

`ifdef RTYPE_SEQ_PERF_EN
  logic [31:0] cycle_cnt_q;
  logic [31:0] retire_cnt_q;

  // Free-wrapping performance counters for busy cycles and retirements.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      if (busy_q)  cycle_cnt_q  <= cycle_cnt_q + 32'd1;
      if (rf_we_q) retire_cnt_q <= retire_cnt_q + 32'd1;
    end
  end

  assign cycle_count  = cycle_cnt_q;
  assign retire_count = retire_cnt_q;
`endif

  assign imem_req  = imem_req_q;
  assign imem_addr = pc_q;
  assign instr     = instr_q;
  assign alu_op    = alu_op_q;
  assign rf_we     = rf_we_q;
  assign pc        = pc_q;
  assign busy      = busy_q;
  assign illegal   = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_rtype_sequencer.sv
// ============================================================================
// Module   : tb_rtype_sequencer
// Purpose  : Self-checking bench for rtype_sequencer: directed scenarios plus
//            random legal R-type streams with random fetch wait states.
// Options  : RTYPE_SEQ_PERF_EN enables the performance counter checks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rtype_sequencer;

  localparam int          MUL_CYC  = 4;
  localparam logic [31:0] RST_PC   = 32'd0;
  localparam logic [31:0] I_ADD    = 32'h002081B3;
  localparam logic [31:0] I_SUB    = 32'h402081B3;
  localparam logic [31:0] I_MUL    = 32'h0020A1B3;
  localparam logic [31:0] I_ADDI   = 32'h00000013;
  localparam logic [31:0] I_F3BAD  = 32'h002031B3;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, run, imem_ack;
  logic [31:0] imem_rdata;
  logic        imem_req, rf_we, busy, illegal;
  logic [31:0] imem_addr, pc, instr;
  logic [3:0]  alu_op;
`ifdef RTYPE_SEQ_PERF_EN
  logic [31:0] cycle_count, retire_count;
`endif

  logic        w_run, w_ack;
  logic [31:0] w_rdata;
  logic        w_req, w_we, w_busy, w_illegal;
  logic [3:0]  w_addr, w_pc, w_alu;
  logic [31:0] w_instr;

  rtype_sequencer #(.PC_WIDTH(32), .RESET_PC(RST_PC), .MUL_CYCLES(MUL_CYC)) u_dut (
    .clk(clk), .reset(reset), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr(instr), .alu_op(alu_op), .rf_we(rf_we),
    .pc(pc), .busy(busy), .illegal(illegal)
`ifdef RTYPE_SEQ_PERF_EN
    , .cycle_count(cycle_count), .retire_count(retire_count)
`endif
  );

  rtype_sequencer #(.PC_WIDTH(4), .RESET_PC(4'd12), .MUL_CYCLES(MUL_CYC)) u_dut_wrap (
    .clk(clk), .reset(reset), .run(w_run),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack),
    .imem_rdata(w_rdata), .instr(w_instr), .alu_op(w_alu), .rf_we(w_we),
    .pc(w_pc), .busy(w_busy), .illegal(w_illegal)
`ifdef RTYPE_SEQ_PERF_EN
    , .cycle_count(), .retire_count()
`endif
  );

  int          n_total = 0;
  int          n_pass  = 0;
  logic [31:0] model_pc;
  logic [3:0]  model_alu;
  bit          in_fetch;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference decoder written directly from the instruction-field rules.
  function automatic bit ref_decode(input logic [31:0] w, output logic [3:0] op, output bit is_mul);
    logic [6:0] f7;
    logic [2:0] f3;
    f7 = w[31:25];
    f3 = w[14:12];
    op = 4'd0;
    is_mul = 1'b0;
    if (w[6:0] != 7'h33) return 1'b0;
    if (f3 == 3'd0) begin
      if (f7 == 7'd0)  begin op = 4'd2; return 1'b1; end
      if (f7 == 7'd32) begin op = 4'd4; return 1'b1; end
      return 1'b0;
    end
    if (f7 != 7'd0) return 1'b0;
    case (f3)
      3'd7: op = 4'd0;
      3'd6: op = 4'd1;
      3'd1: op = 4'd3;
      3'd5: op = 4'd5;
      3'd2: begin op = 4'd6; is_mul = 1'b1; end
      3'd4: op = 4'd7;
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; imem_ack = 1'b0; w_run = 1'b0; w_ack = 1'b0;
    step(); step();
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_we", rf_we, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_pc", pc, RST_PC);
    chk("rst_instr", instr, 0);
    chk("rst_alu", alu_op, 0);
    model_pc = RST_PC;
    model_alu = 4'd0;
    in_fetch = 1'b0;
  endtask

  // From IDLE: raise run and land on the first FETCH cycle.
  task automatic start_run();
    run = 1'b1;
    step();
    chk("start_req", imem_req, 1);
    chk("start_busy", busy, 1);
    in_fetch = 1'b1;
  endtask

  // Called on the first FETCH cycle; runs one legal instruction through WB.
  task automatic do_instr(input logic [31:0] word, input int waits, input bit run_next);
    logic [3:0] op;
    bit         is_mul, legal, seen_we;
    int         exp_lat, cyc;
    legal   = ref_decode(word, op, is_mul);
    exp_lat = waits + (is_mul ? 3 + MUL_CYC : 4);
    run     = run_next;
    seen_we = 1'b0;
    cyc     = 0;
    while (cyc < 40 && !seen_we) begin
      if (imem_req) begin
        chk("fetch_addr", imem_addr, model_pc);
        chk("req_window", (cyc <= waits), 1);
        imem_ack   = (cyc == waits);
        imem_rdata = (cyc == waits) ? word : $urandom;
      end else begin
        imem_ack = 1'b0;
      end
      if (rf_we) begin
        seen_we = 1'b1;
        chk("we_latency", cyc + 1, exp_lat);
        chk("we_no_req", imem_req, 0);
        chk("wb_alu", alu_op, op);
        chk("wb_instr", instr, word);
        chk("wb_pc", pc, model_pc);
      end
      step();
      cyc++;
    end
    imem_ack = 1'b0;
    chk("we_seen", seen_we, legal);
    model_pc  = model_pc + 32'd4;
    model_alu = op;
    chk("pc_next", pc, model_pc);
    chk("we_one_cycle", rf_we, 0);
    chk("next_req", imem_req, run_next);
    chk("next_busy", busy, run_next);
    in_fetch = run_next;
  endtask

  // Called on the first FETCH cycle; the word must decode as illegal.
  task automatic do_illegal(input logic [31:0] word);
    run = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = word;
    step();
    imem_ack = 1'b0;
    chk("ill_decode_we", rf_we, 0);
    step();
    chk("ill_flag", illegal, 1);
    for (int i = 0; i < 5; i++) begin
      chk("ill_busy", busy, 0);
      chk("ill_req", imem_req, 0);
      chk("ill_we", rf_we, 0);
      chk("ill_pc", pc, model_pc);
      chk("ill_alu", alu_op, model_alu);
      chk("ill_sticky", illegal, 1);
      step();
    end
  endtask

  logic [9:0] legal_tab [8];

  initial begin
    legal_tab = '{ {7'h00, 3'd0}, {7'h20, 3'd0}, {7'h00, 3'd7}, {7'h00, 3'd6},
                   {7'h00, 3'd1}, {7'h00, 3'd5}, {7'h00, 3'd2}, {7'h00, 3'd4} };
    imem_rdata = '0;
    w_rdata = '0;
    @(negedge clk);
    do_reset();

    // Three zero-wait ADDs, ending in IDLE.
    start_run();
    do_instr(I_ADD, 0, 1);
    do_instr(I_ADD, 0, 1);
    do_instr(I_ADD, 0, 0);
`ifdef RTYPE_SEQ_PERF_EN
    chk("perf_retire", retire_count, 3);
    chk("perf_cycles", cycle_count, 12);
    step(); step();
    chk("perf_cycles_idle", cycle_count, 12);
`endif
    // run=0 at WB: no fresh request.
    step();
    chk("idle_no_req", imem_req, 0);
    chk("idle_busy", busy, 0);

    // SUB, MUL back-to-back, then a 3-wait fetch.
    start_run();
    do_instr(I_SUB, 0, 1);
    do_instr(I_MUL, 0, 1);
    do_instr(I_ADD, 3, 1);

    // Random legal stream with random wait states and run drops.
    for (int n = 0; n < 30; n++) begin
      logic [9:0]  ent;
      logic [31:0] word;
      if (!in_fetch) start_run();
      ent  = legal_tab[$urandom_range(0, 7)];
      word = {ent[9:3], 5'($urandom), 5'($urandom), ent[2:0], 5'($urandom), 7'h33};
      do_instr(word, $urandom_range(0, 3), ($urandom_range(0, 3) != 0));
    end

    // Illegal addi halts with pc frozen; reset recovers.
    if (!in_fetch) start_run();
    do_illegal(I_ADDI);
    do_reset();

    // Illegal funct3=3.
    start_run();
    do_illegal(I_F3BAD);
    do_reset();

    // Reset during the second EXEC cycle of a MUL.
    start_run();
    do_instr(I_ADD, 0, 1);
    imem_ack = 1'b1; imem_rdata = I_MUL;
    step();
    imem_ack = 1'b0;
    chk("mulrst_dec_we", rf_we, 0);
    step();
    chk("mulrst_ex1_we", rf_we, 0);
    step();
    chk("mulrst_ex2_we", rf_we, 0);
    reset = 1'b1; run = 1'b0;
    step();
    reset = 1'b0;
    chk("mulrst_busy", busy, 0);
    chk("mulrst_pc", pc, RST_PC);
    chk("mulrst_we", rf_we, 0);
    chk("mulrst_req", imem_req, 0);
    for (int i = 0; i < 6; i++) begin
      chk("mulrst_we_after", rf_we, 0);
      step();
    end

    // Narrow PC instance: 12 wraps to 0 after one ADD.
    w_run = 1'b1;
    step();
    chk("wrap_req", w_req, 1);
    chk("wrap_addr", w_addr, 12);
    w_ack = 1'b1; w_rdata = I_ADD; w_run = 1'b0;
    step();
    w_ack = 1'b0;
    step();
    step();
    chk("wrap_we", w_we, 1);
    chk("wrap_alu", w_alu, 2);
    chk("wrap_pc_wb", w_pc, 12);
    step();
    chk("wrap_pc", w_pc, 0);
    chk("wrap_busy", w_busy, 0);
    chk("wrap_illegal", w_illegal, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
